hdr_field_decoder: RTL and testbench
====================================

Name: hdr_field_decoder

Overview:
- Per-port header field extractor feeding the write arbiter.
- On each input port's header beat, latches priority, destination port and packet length from configurable bit offsets.
- Holds the fields independently per port until that port's end-of-packet, so ports capture and release without a global lock.
- Also provides a combinational pre-decode priority view for look-ahead arbitration.

Parameters:
- DATA_WIDTH, 64, width of one port's data word
- NUM_PORTS, 16, number of input ports/channels
- PRI_WIDTH, 3, priority field width
- PRI_LSB, 4, priority field LSB within the word
- DES_WIDTH, 4, destination port field width
- DES_LSB, 0, destination field LSB
- LEN_WIDTH, 7, packet length field width
- LEN_LSB, 7, length field LSB

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_in  in  DATA_WIDTH*NUM_PORTS  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- sop  in  NUM_PORTS  header beat valid on port i
- eop  in  NUM_PORTS  last beat of port i's packet
- pri_out  out  PRI_WIDTH*NUM_PORTS  latched priority per port
- des_out  out  DES_WIDTH*NUM_PORTS  latched destination per port
- len_out  out  LEN_WIDTH*NUM_PORTS  latched length per port
- hdr_valid  out  NUM_PORTS  fields of port i are held and valid
- hdr_err  out  NUM_PORTS  latched header malformed (len==0 or des>=NUM_PORTS)
- pre_pri_out  out  PRI_WIDTH*NUM_PORTS  combinational priority of the current data_in

Behaviour:
- Reset (clock edge with rst=1): all registered outputs 0; every port in IDLE; overrides any sop/eop in the same cycle.
- Per-port FSM, two states, fully independent per port:
  - IDLE, sop[i]=1: capture fields of port i; go to HELD; hdr_valid[i]=1 from the next cycle (1-cycle latency).
  - IDLE, sop[i]=0: outputs of port i stay 0.
  - HELD, eop[i]=1 and sop[i]=0: go to IDLE; pri/des/len/hdr_valid/hdr_err of port i cleared to 0 next cycle.
  - HELD, eop[i]=1 and sop[i]=1 (back-to-back packet): recapture new fields; stay HELD; hdr_valid[i] stays 1, no bubble.
  - HELD, sop[i]=1 and eop[i]=0: header ignored; fields unchanged (counted if the optional feature is on).
  - HELD, neither: hold.
  - IDLE, eop[i]=1 with no sop: ignored.
- Field extraction: pure bit slices at the given LSBs; no arithmetic.
- Parameter check: LSB+WIDTH <= DATA_WIDTH for each field; elaboration error otherwise.
- hdr_err[i]: set at capture when the length field == 0, or when DES_WIDTH can encode a value >= NUM_PORTS and it does. The fields are still latched; the downstream stage decides.
- pre_pri_out: combinational slice of data_in for every port, regardless of sop or state.

Optional Feature:
- HDR_DROP_CNT_EN
  - Defined: adds output drop_cnt (16*NUM_PORTS bits) with a per-port 16-bit saturating counter.
    - Increments on each ignored header (HELD, sop=1, eop=0).
    - Saturates at 16'hFFFF.
    - Cleared by rst only.
  - Undefined: no port, no counter logic; ignored headers are silently dropped.

Decomposition:
- Shared package: field LSB/width defaults and the FSM state encoding (IDLE=0, HELD=1), for reuse by the arbiter and the pack-length counter.
- Sub-module hdr_port_slot: the per-port FSM, field registers, error flag and optional counter.
- Top instantiates NUM_PORTS slots with a generate loop and adds the combinational pre_pri slicing.

Test Plan:
- Reset mid-packet: port 3 HELD with pri=5, then rst=1 for one cycle -> next cycle hdr_valid=0, pri_out=0; sop one cycle later recaptures normally.
- Capture/release: port 0 word with pri=6, des=9, len=64, sop=1 -> next cycle pri=6, des=9, len=64, hdr_valid[0]=1; eop[0] -> next cycle all fields of port 0 are 0.
- Independence: port 2 HELD; eop[2]=0 and sop[5]=1 with pri=3 -> port 5 captures pri=3; port 2 unchanged.
- Back-to-back: port 7 HELD (len=10); eop[7]=1 and sop[7]=1 with len=20 in the same cycle -> hdr_valid[7] never drops; len_out=20.
- Ignored header and error: port 1 HELD; sop[1]=1 with eop=0 and pri=1 -> fields unchanged and drop_cnt[1]=1 if enabled; later capture with len=0 -> hdr_err[1]=1.
- Non-default parameters: NUM_PORTS=4, PRI_LSB=8, PRI_WIDTH=4; word with bits[11:8]=0xA -> pri_out=0xA and pre_pri_out=0xA combinationally.

Source files
------------

// File: rtl/hdr_field_decoder_pkg.sv
// hdr_field_decoder_pkg: default field geometry and slot state encoding shared with the arbiter and pack-length counter.
package hdr_field_decoder_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_PORTS  = 16;
  localparam int DEF_PRI_WIDTH  = 3;
  localparam int DEF_PRI_LSB    = 4;
  localparam int DEF_DES_WIDTH  = 4;
  localparam int DEF_DES_LSB    = 0;
  localparam int DEF_LEN_WIDTH  = 7;
  localparam int DEF_LEN_LSB    = 7;
  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} slot_state_e;
endpackage

// File: rtl/hdr_port_slot.sv
// hdr_port_slot: one port's capture/hold FSM, field registers and error flag.
// With HDR_DROP_CNT_EN defined, also counts headers ignored while a packet is held.
module hdr_port_slot
  import hdr_field_decoder_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int PRI_WIDTH = DEF_PRI_WIDTH,
  parameter int DES_WIDTH = DEF_DES_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRI_WIDTH-1:0] pri_i,
  input  logic [DES_WIDTH-1:0] des_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 sop_i,
  input  logic                 eop_i,
  output logic [PRI_WIDTH-1:0] pri_o,
  output logic [DES_WIDTH-1:0] des_o,
  output logic [LEN_WIDTH-1:0] len_o,
  output logic                 valid_o,
  output logic                 err_o
`ifdef HDR_DROP_CNT_EN
  ,
  output logic [15:0]          drop_cnt_o
`endif
);
  // The destination check only exists when the field can name a nonexistent port.
  localparam bit DES_CHK = (2 ** DES_WIDTH) > NUM_PORTS;
  slot_state_e          state_q, state_d;
  logic [PRI_WIDTH-1:0] pri_q, pri_d;
  logic [DES_WIDTH-1:0] des_q, des_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 err_q, err_d;
  logic                 cap, rel, err_f;
  assign cap   = sop_i && (state_q == IDLE || eop_i);
  assign rel   = state_q == HELD && eop_i && !sop_i;
  assign err_f = (len_i == '0) || (DES_CHK && 32'(des_i) >= NUM_PORTS);
  always_comb begin
    state_d = cap ? HELD  : rel ? IDLE : state_q;
    pri_d   = cap ? pri_i : rel ? '0   : pri_q;
    des_d   = cap ? des_i : rel ? '0   : des_q;
    len_d   = cap ? len_i : rel ? '0   : len_q;
    err_d   = cap ? err_f : rel ? 1'b0 : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pri_q   <= '0;
      des_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      des_q   <= des_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end
  assign pri_o   = pri_q;
  assign des_o   = des_q;
  assign len_o   = len_q;
  assign valid_o = state_q == HELD;
  assign err_o   = err_q;
`ifdef HDR_DROP_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == HELD && sop_i && !eop_i && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign drop_cnt_o = cnt_q;
`endif
endmodule

// File: rtl/hdr_field_decoder.sv
// hdr_field_decoder: per-port header field capture plus combinational look-ahead priority.
// Optional HDR_DROP_CNT_EN adds per-port 16-bit saturating ignored-header counters on drop_cnt.
module hdr_field_decoder
  import hdr_field_decoder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int PRI_WIDTH  = DEF_PRI_WIDTH,
  parameter int PRI_LSB    = DEF_PRI_LSB,
  parameter int DES_WIDTH  = DEF_DES_WIDTH,
  parameter int DES_LSB    = DEF_DES_LSB,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int LEN_LSB    = DEF_LEN_LSB
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH*NUM_PORTS-1:0] data_in,
  input  logic [NUM_PORTS-1:0]            sop,
  input  logic [NUM_PORTS-1:0]            eop,
  output logic [PRI_WIDTH*NUM_PORTS-1:0]  pri_out,
  output logic [DES_WIDTH*NUM_PORTS-1:0]  des_out,
  output logic [LEN_WIDTH*NUM_PORTS-1:0]  len_out,
  output logic [NUM_PORTS-1:0]            hdr_valid,
  output logic [NUM_PORTS-1:0]            hdr_err,
  output logic [PRI_WIDTH*NUM_PORTS-1:0]  pre_pri_out
`ifdef HDR_DROP_CNT_EN
  ,
  output logic [16*NUM_PORTS-1:0]         drop_cnt
`endif
);
  if (PRI_LSB + PRI_WIDTH > DATA_WIDTH || DES_LSB + DES_WIDTH > DATA_WIDTH ||
      LEN_LSB + LEN_WIDTH > DATA_WIDTH) begin : g_bad_geometry
    $error("hdr_field_decoder: header field extends past DATA_WIDTH");
  end
  // Header words carry payload bits outside the three fields.
  logic unused_data;
  assign unused_data = ^data_in;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [DATA_WIDTH-1:0] w;
    assign w = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    assign pre_pri_out[i*PRI_WIDTH +: PRI_WIDTH] = w[PRI_LSB +: PRI_WIDTH];
    hdr_port_slot #(
      .NUM_PORTS(NUM_PORTS),
      .PRI_WIDTH(PRI_WIDTH),
      .DES_WIDTH(DES_WIDTH),
      .LEN_WIDTH(LEN_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .pri_i     (w[PRI_LSB +: PRI_WIDTH]),
      .des_i     (w[DES_LSB +: DES_WIDTH]),
      .len_i     (w[LEN_LSB +: LEN_WIDTH]),
      .sop_i     (sop[i]),
      .eop_i     (eop[i]),
      .pri_o     (pri_out[i*PRI_WIDTH +: PRI_WIDTH]),
      .des_o     (des_out[i*DES_WIDTH +: DES_WIDTH]),
      .len_o     (len_out[i*LEN_WIDTH +: LEN_WIDTH]),
      .valid_o   (hdr_valid[i]),
      .err_o     (hdr_err[i])
`ifdef HDR_DROP_CNT_EN
      ,
      .drop_cnt_o(drop_cnt[i*16 +: 16])
`endif
    );
  end
endmodule

// File: tb/tb_hdr_field_decoder.sv
// tb_hdr_field_decoder: directed vector table plus hand sequences for reset, drop counting and alternate geometry.
module tb_hdr_field_decoder;
  logic clk = 1'b0;
  logic rst;
  logic [1023:0] data_in;
  logic [15:0] sop, eop, hdr_valid, hdr_err;
  logic [47:0] pri_out, pre_pri;
  logic [63:0] des_out;
  logic [111:0] len_out;
  logic [255:0] d4;
  logic [3:0] sop4, eop4, v4, e4;
  logic [15:0] pri4, des4, pp4;
  logic [27:0] len4;
`ifdef HDR_DROP_CNT_EN
  logic [255:0] drop_cnt;
  logic [63:0] dc4;
`endif
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  hdr_field_decoder dut (
    .clk(clk), .rst(rst), .data_in(data_in), .sop(sop), .eop(eop),
    .pri_out(pri_out), .des_out(des_out), .len_out(len_out),
    .hdr_valid(hdr_valid), .hdr_err(hdr_err), .pre_pri_out(pre_pri)
`ifdef HDR_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );
  hdr_field_decoder #(.NUM_PORTS(4), .PRI_LSB(8), .PRI_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(d4), .sop(sop4), .eop(eop4),
    .pri_out(pri4), .des_out(des4), .len_out(len4),
    .hdr_valid(v4), .hdr_err(e4), .pre_pri_out(pp4)
`ifdef HDR_DROP_CNT_EN
    , .drop_cnt(dc4)
`endif
  );
  typedef struct {
    int p;
    logic [2:0] pri;
    logic [3:0] des;
    logic [6:0] len;
    logic [15:0] sop;
    logic [15:0] eop;
    int c;
    logic [2:0] epri;
    logic [3:0] edes;
    logic [6:0] elen;
    logic ev;
    logic ee;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic drive(input int p, input logic [2:0] pri, input logic [3:0] des, input logic [6:0] len,
                       input logic [15:0] s, input logic [15:0] e);
    data_in = '0;
    data_in[p*64 +: 64] = (64'(len) << 7) | (64'(pri) << 4) | 64'(des);
    sop = s;
    eop = e;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{0, 3'd6, 4'd9, 7'd64, 16'h0001, 16'h0000, 0, 3'd6, 4'd9, 7'd64, 1'b1, 1'b0};
    v[1]  = '{0, 3'd0, 4'd0, 7'd0,  16'h0000, 16'h0001, 0, 3'd0, 4'd0, 7'd0,  1'b0, 1'b0};
    v[2]  = '{2, 3'd1, 4'd2, 7'd5,  16'h0004, 16'h0000, 2, 3'd1, 4'd2, 7'd5,  1'b1, 1'b0};
    v[3]  = '{5, 3'd3, 4'd4, 7'd8,  16'h0020, 16'h0000, 5, 3'd3, 4'd4, 7'd8,  1'b1, 1'b0};
    v[4]  = '{5, 3'd0, 4'd0, 7'd0,  16'h0000, 16'h0000, 2, 3'd1, 4'd2, 7'd5,  1'b1, 1'b0};
    v[5]  = '{7, 3'd2, 4'd7, 7'd10, 16'h0080, 16'h0000, 7, 3'd2, 4'd7, 7'd10, 1'b1, 1'b0};
    v[6]  = '{7, 3'd4, 4'd8, 7'd20, 16'h0080, 16'h0080, 7, 3'd4, 4'd8, 7'd20, 1'b1, 1'b0};
    v[7]  = '{1, 3'd5, 4'd1, 7'd3,  16'h0002, 16'h0000, 1, 3'd5, 4'd1, 7'd3,  1'b1, 1'b0};
    v[8]  = '{1, 3'd1, 4'd6, 7'd9,  16'h0002, 16'h0000, 1, 3'd5, 4'd1, 7'd3,  1'b1, 1'b0};
    v[9]  = '{1, 3'd0, 4'd0, 7'd0,  16'h0000, 16'h0002, 1, 3'd0, 4'd0, 7'd0,  1'b0, 1'b0};
    v[10] = '{1, 3'd2, 4'd3, 7'd0,  16'h0002, 16'h0000, 1, 3'd2, 4'd3, 7'd0,  1'b1, 1'b1};
    v[11] = '{1, 3'd0, 4'd0, 7'd0,  16'h0000, 16'h0002, 1, 3'd0, 4'd0, 7'd0,  1'b0, 1'b0};
    v[12] = '{9, 3'd0, 4'd0, 7'd0,  16'h0000, 16'h0200, 9, 3'd0, 4'd0, 7'd0,  1'b0, 1'b0};
    v[13] = '{4, 3'd7, 4'd15, 7'd127, 16'h0010, 16'h0000, 4, 3'd7, 4'd15, 7'd127, 1'b1, 1'b0};
    rst = 1'b1;
    data_in = '0; sop = '0; eop = '0;
    d4 = '0; sop4 = '0; eop4 = '0;
    tick; tick;
    chk("reset pri_out", 32'(pri_out != '0), 0);
    chk("reset hdr_valid", 32'(hdr_valid), 0);
    chk("reset hdr_err", 32'(hdr_err), 0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(v[i].p, v[i].pri, v[i].des, v[i].len, v[i].sop, v[i].eop);
      #1;
      chk($sformatf("v%0d pre_pri", i), 32'(pre_pri[v[i].p*3 +: 3]), 32'(v[i].pri));
      tick;
      chk($sformatf("v%0d pri", i), 32'(pri_out[v[i].c*3 +: 3]), 32'(v[i].epri));
      chk($sformatf("v%0d des", i), 32'(des_out[v[i].c*4 +: 4]), 32'(v[i].edes));
      chk($sformatf("v%0d len", i), 32'(len_out[v[i].c*7 +: 7]), 32'(v[i].elen));
      chk($sformatf("v%0d valid", i), 32'(hdr_valid[v[i].c]), 32'(v[i].ev));
      chk($sformatf("v%0d err", i), 32'(hdr_err[v[i].c]), 32'(v[i].ee));
    end
    drive(0, 3'd0, 4'd0, 7'd0, 16'h0000, 16'h0000);
`ifdef HDR_DROP_CNT_EN
    chk("drop_cnt port1", 32'(drop_cnt[16 +: 16]), 1);
    chk("drop_cnt port7", 32'(drop_cnt[7*16 +: 16]), 0);
`endif
    drive(3, 3'd5, 4'd3, 7'd12, 16'h0008, 16'h0000);
    tick;
    chk("rmp held pri", 32'(pri_out[9 +: 3]), 5);
    chk("rmp held valid", 32'(hdr_valid[3]), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rmp reset valid", 32'(hdr_valid[3]), 0);
    chk("rmp reset pri", 32'(pri_out[9 +: 3]), 0);
    chk("rmp reset port4", 32'(hdr_valid[4]), 0);
`ifdef HDR_DROP_CNT_EN
    chk("rmp reset drop_cnt", 32'(drop_cnt[16 +: 16]), 0);
`endif
    drive(3, 3'd0, 4'd0, 7'd0, 16'h0000, 16'h0000);
    tick;
    chk("rmp idle valid", 32'(hdr_valid[3]), 0);
    drive(3, 3'd5, 4'd3, 7'd12, 16'h0008, 16'h0000);
    tick;
    chk("rmp recapture pri", 32'(pri_out[9 +: 3]), 5);
    chk("rmp recapture len", 32'(len_out[21 +: 7]), 12);
    chk("rmp recapture valid", 32'(hdr_valid[3]), 1);
    drive(3, 3'd0, 4'd0, 7'd0, 16'h0000, 16'h0000);
    d4[2*64 +: 64] = 64'hA00;
    #1;
    chk("p4 pre_pri comb", 32'(pp4[8 +: 4]), 32'hA);
    sop4 = 4'b0100;
    tick;
    chk("p4 pri", 32'(pri4[8 +: 4]), 32'hA);
    chk("p4 len", 32'(len4[14 +: 7]), 32'h14);
    chk("p4 valid", 32'(v4), 32'h4);
    chk("p4 err clean", 32'(e4[2]), 0);
    d4[0 +: 64] = 64'hA05;
    sop4 = 4'b0001;
    tick;
    chk("p4 des err", 32'(e4[0]), 1);
    chk("p4 des latched", 32'(des4[0 +: 4]), 5);
    sop4 = '0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
